// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and helpers for the pipeline hazard controller
package pipe_pkg;

    localparam int FWD_RF = 0;
    // Widest register address an entry can hold; AW must not exceed it.
    localparam int MAX_AW = 8;

    typedef struct packed {
        logic              valid;
        logic [MAX_AW-1:0] wreg;
        logic              regwrite;
        logic              memread;
    } sb_entry_t;

    function automatic int fsel_width(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_match.sv
// rtl/pipe_hazard_ctrl_match.sv - per-operand youngest-match compare, forward select and stall
module hazard_match
    import pipe_pkg::*;
#(
    parameter int DEPTH      = 3,
    parameter int AW         = 5,
    parameter int FWD_EN     = 1,
    parameter int LOAD_READY = 2,
    parameter int RF_BYPASS  = 1,
    parameter int FSW        = 2
) (
    input  sb_entry_t [DEPTH-1:0] entries,
    input  logic [AW-1:0]         src,
    input  logic                  use_src,
    output logic                  hit,
    output logic [FSW-1:0]        idx,
    output logic                  stall_req
);

    logic [MAX_AW-1:0] src_x;
    logic              load;
    int                k;
    int                need;

    always_comb begin
        src_x          = '0;
        src_x[AW-1:0]  = src;
        hit            = 1'b0;
        load           = 1'b0;
        k              = 0;
        // Scan oldest to youngest so the lowest-index match is the one kept.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (use_src && (src != '0) && entries[i].valid && entries[i].regwrite &&
                (entries[i].wreg == src_x)) begin
                hit  = 1'b1;
                k    = i;
                load = entries[i].memread;
            end
        end

        need      = load ? LOAD_READY : 1;
        stall_req = 1'b0;
        if (hit) begin
            if (FWD_EN != 0) stall_req = (k + 1 < need);
            else             stall_req = (k <= DEPTH - 2);
            if ((RF_BYPASS == 0) && (k == DEPTH - 1)) stall_req = 1'b1;
        end

        idx = FSW'(FWD_RF);
        if (hit && !stall_req && (k + 1 <= DEPTH - 1)) idx = FSW'(k + 1);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - scoreboard-based stall/flush/forwarding controller for the N-stage pipeline
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int DEPTH      = 3,
    parameter int AW         = 5,
    parameter int FWD_EN     = 1,
    parameter int LOAD_READY = 2,
    parameter int BR_ENTRY   = 1,
    parameter int RF_BYPASS  = 1,
    localparam int FSW       = fsel_width(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           id_valid,
    input  logic [AW-1:0]  id_rs,
    input  logic [AW-1:0]  id_rt,
    input  logic           id_use_rs,
    input  logic           id_use_rt,
    input  logic [AW-1:0]  id_wreg,
    input  logic           id_regwrite,
    input  logic           id_memread,
    input  logic           id_jump,
    input  logic           br_taken,
    output logic           stall,
    output logic           flush_ifid,
    output logic           bubble_idex,
    output logic [FSW-1:0] ex_fwd_a,
    output logic [FSW-1:0] ex_fwd_b
);

    sb_entry_t [DEPTH-1:0] entries;
    sb_entry_t             id_entry;
    logic                  hit_a, hit_b;
    logic                  stall_a, stall_b;
    logic [FSW-1:0]        idx_a, idx_b;
    logic [FSW-1:0]        fwd_a_nxt, fwd_b_nxt;
    logic                  raw_stall;

    hazard_match #(
        .DEPTH(DEPTH), .AW(AW), .FWD_EN(FWD_EN), .LOAD_READY(LOAD_READY),
        .RF_BYPASS(RF_BYPASS), .FSW(FSW)
    ) u_match_rs (
        .entries(entries), .src(id_rs), .use_src(id_use_rs),
        .hit(hit_a), .idx(idx_a), .stall_req(stall_a)
    );

    hazard_match #(
        .DEPTH(DEPTH), .AW(AW), .FWD_EN(FWD_EN), .LOAD_READY(LOAD_READY),
        .RF_BYPASS(RF_BYPASS), .FSW(FSW)
    ) u_match_rt (
        .entries(entries), .src(id_rt), .use_src(id_use_rt),
        .hit(hit_b), .idx(idx_b), .stall_req(stall_b)
    );

    always_comb begin
        raw_stall   = id_valid & (stall_a | stall_b);
        // A taken branch squashes ID, so any hazard it had is moot.
        stall       = raw_stall & ~br_taken;
        bubble_idex = br_taken | stall;
        flush_ifid  = br_taken | (id_jump & ~raw_stall);

        fwd_a_nxt = (bubble_idex || !id_valid || !hit_a) ? '0 : idx_a;
        fwd_b_nxt = (bubble_idex || !id_valid || !hit_b) ? '0 : idx_b;

        id_entry               = '0;
        id_entry.valid         = id_valid & ~bubble_idex;
        id_entry.wreg[AW-1:0]  = id_wreg;
        id_entry.regwrite      = id_regwrite;
        id_entry.memread       = id_memread;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entries  <= '0;
            ex_fwd_a <= '0;
            ex_fwd_b <= '0;
        end else begin
            for (int i = DEPTH - 1; i >= 1; i--) begin
                entries[i] <= entries[i-1];
                // Instructions younger than the taken branch are wrong-path.
                if (br_taken && ((i - 1) < BR_ENTRY)) entries[i].valid <= 1'b0;
            end
            entries[0] <= id_entry;
            ex_fwd_a   <= fwd_a_nxt;
            ex_fwd_b   <= fwd_b_nxt;
        end
    end

endmodule
